ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Owns the architectural PC register and turns each PC into one instruction.
//  Per instruction: issue a read to instruction memory, capture the word, present it to decode/execute.
//  Presents the current PC to the next-PC logic (pc_o) and loads the computed next PC (npc_i) when the core retires the instruction.
//  Sits between instruction memory and the single-issue core datapath.
// PARAMETERS
//  RESET_PC   32'h0000_3000   PC value loaded on reset (text segment base)
//  CNT_W      32              width of retired-instruction counter
// PORTS
//  clk             in   1      single clock, all state on rising edge
//  rst             in   1      synchronous, active-high reset
//  npc_i           in   32     next PC from next-PC logic, sampled on retire
//  pc_o            out  32     current PC register, to next-PC logic
//  imem_req_valid  out  1      read request valid
//  imem_req_ready  in   1      memory accepts request
//  imem_addr       out  32     read byte address (== pc_o)
//  imem_resp_valid in   1      read data valid (one pulse per accepted request)
//  imem_resp_data  in   32     instruction word
//  inst_valid      out  1      instruction presented to core
//  inst_ready      in   1      core retires presented instruction this cycle
//  inst_data       out  32     captured instruction word
//  inst_pc         out  32     PC of inst_data (== pc_o while inst_valid)
//  fetch_fault     out  1      sticky: misaligned next PC detected
//  fault_pc        out  32     offending npc_i value
//  retired_cnt     out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  Reset (rst=1 at edge, any state): state=IDLE, pc_o=RESET_PC, imem_req_valid=0,
//   inst_valid=0, inst_data=0, fetch_fault=0, fault_pc=0, retired_cnt=0.
//   Any in-flight request is abandoned; imem is reset by the same rst.
//  FSM states: IDLE, REQ, WAIT, ISSUE, FAULT.
//  IDLE : all outputs idle; next state REQ unconditionally (one cycle after reset release).
//  REQ  : imem_req_valid=1, imem_addr=pc_o held stable until accepted;
//         req_valid && req_ready -> WAIT; otherwise stay in REQ.
//         imem_resp_valid in REQ is ignored.
//  WAIT : imem_req_valid=0; on imem_resp_valid capture imem_resp_data into inst_data -> ISSUE.
//         No timeout; waits indefinitely.
//  ISSUE: inst_valid=1; inst_data/inst_pc stable while inst_ready=0 (stall).
//         On inst_ready: pc_o<=npc_i, retired_cnt+=1 (wraps modulo 2^CNT_W).
//           npc_i[1:0]==0: next state REQ.
//           npc_i[1:0]!=0: next state FAULT, fetch_fault<=1, fault_pc<=npc_i.
//  FAULT: no requests, inst_valid=0; remains until rst.
//  inst_valid is registered (asserted the cycle after the response is captured).
//  Minimum cycles per instruction: 3 (REQ accepted, WAIT response, ISSUE retire).
//  Response latency: >=1 cycle after acceptance; at most one request outstanding.
//  npc_i is sampled only in ISSUE with inst_ready=1; it is don't-care otherwise.
//  Simultaneous rst with inst_ready: reset wins; counter not incremented.
// TESTING
//  1 Reset, mem ready=1, 1-cycle latency -> first imem_addr=0x3000 in 2nd cycle after rst release;
//    inst_valid 2 cycles later with the word at 0x3000.
//  2 inst_ready=1 every cycle, npc_i=pc_o+4 -> addrs 0x3000,0x3004,0x3008 every 3 cycles;
//    retired_cnt=3 after third retire.
//  3 Hold imem_req_ready=0 for 5 cycles -> imem_addr/req_valid stable;
//    hold inst_ready=0 for 4 cycles -> inst_data and inst_pc unchanged.
//  4 Retire with npc_i=0x0000_3102 -> fetch_fault=1, fault_pc=0x3102, no further requests;
//    rst clears to RESET_PC.
//  5 Assert rst while in WAIT, then drive a stale imem_resp_valid in IDLE/REQ -> ignored;
//    fetch restarts at 0x3000.
//  6 Jump: npc_i=0x0040_0000 on retire -> next imem_addr=0x0040_0000, inst_pc matches.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the architectural PC, fetches one word per instruction
// from instruction memory and holds it for the core until it is retired.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      npc_i,
  output logic [31:0]      pc_o,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_data,
  output logic [31:0]      inst_pc,
  output logic             fetch_fault,
  output logic [31:0]      fault_pc,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0] state;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Request valid/address hold until accepted; the response is a single-cycle
  // pulse that is only honoured while waiting; the instruction is held until
  // the core retires it with inst_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc_o        <= RESET_PC;
      inst_data   <= 32'h0;
      fetch_fault <= 1'b0;
      fault_pc    <= 32'h0;
      retired_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            inst_data <= imem_resp_data;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (inst_ready) begin
            pc_o        <= npc_i;
            retired_cnt <= retired_cnt + CNT_W'(1);
            // A misaligned target is never fetched; the unit parks until reset.
            if (npc_i[1:0] != 2'b00) begin
              state       <= S_FAULT;
              fetch_fault <= 1'b1;
              fault_pc    <= npc_i;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc_o;
  assign inst_valid     = (state == S_ISSUE);
  assign inst_pc        = pc_o;
  assign dbg_state      = state;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed plus randomized bench for ifetch_unit: the bench plays instruction
// memory and the core, and keeps a PC/counter/fault model plus a word table.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc_i;
  logic [31:0] pc_o;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] retired_cnt;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic        exp_fault;
  logic [31:0] exp_fault_pc;
  logic [31:0] mem_words [logic [31:0]];

  ifetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .npc_i           (npc_i),
    .pc_o            (pc_o),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .fetch_fault     (fetch_fault),
    .fault_pc        (fault_pc),
    .retired_cnt     (retired_cnt),
    .dbg_state       (dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    if (!mem_words.exists(addr)) mem_words[addr] = $urandom;
    return mem_words[addr];
  endfunction

  task automatic model_reset();
    exp_pc       = 32'h0000_3000;
    exp_cnt      = 0;
    exp_fault    = 1'b0;
    exp_fault_pc = 32'h0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},       pc_o,           32'h0000_3000);
    check({tag, "_reqv"},     {31'h0, imem_req_valid}, 32'h0);
    check({tag, "_instv"},    {31'h0, inst_valid},     32'h0);
    check({tag, "_fault"},    {31'h0, fetch_fault},    32'h0);
    check({tag, "_fault_pc"}, fault_pc,       32'h0);
    check({tag, "_cnt"},      retired_cnt,    32'h0);
  endtask

  // Driver: starting in the request phase, get the instruction to the core.
  task automatic goto_issue(input int rdy_wait, input int lat);
    logic [31:0] w;
    check("req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < rdy_wait; i++) begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = ($urandom_range(0, 1) == 1);
      imem_resp_data  = $urandom;
      tick();
      check("req_hold_valid", {31'h0, imem_req_valid}, 32'h1);
      check("req_hold_addr", imem_addr, exp_pc);
    end
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("wait_reqv", {31'h0, imem_req_valid}, 32'h0);
    check("wait_instv", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < lat; i++) begin
      imem_resp_data = $urandom;
      tick();
      check("wait_lat_instv", {31'h0, inst_valid}, 32'h0);
    end
    w = word_at(exp_pc);
    imem_resp_valid = 1'b1;
    imem_resp_data  = w;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    check("issue_valid", {31'h0, inst_valid}, 32'h1);
    check("issue_data", inst_data, w);
    check("issue_pc", inst_pc, exp_pc);
  endtask

  // Driver: stall the core, then retire with the given next PC.
  task automatic retire(input int stall, input logic [31:0] npc);
    logic [31:0] w;
    w = word_at(exp_pc);
    for (int i = 0; i < stall; i++) begin
      inst_ready = 1'b0;
      npc_i      = $urandom;
      tick();
      check("stall_valid", {31'h0, inst_valid}, 32'h1);
      check("stall_data", inst_data, w);
      check("stall_pc", inst_pc, exp_pc);
      check("stall_cnt", retired_cnt, exp_cnt);
    end
    inst_ready = 1'b1;
    npc_i      = npc;
    tick();
    inst_ready = 1'b0;
    npc_i      = $urandom;
    exp_cnt = exp_cnt + 1;
    exp_pc  = npc;
    if (npc[1:0] != 2'b00) begin
      exp_fault    = 1'b1;
      exp_fault_pc = npc;
    end
    check("ret_cnt", retired_cnt, exp_cnt);
    check("ret_pc", pc_o, exp_pc);
    check("ret_fault", {31'h0, fetch_fault}, {31'h0, exp_fault});
    check("ret_fault_pc", fault_pc, exp_fault_pc);
    check("ret_instv", {31'h0, inst_valid}, 32'h0);
    check("ret_reqv", {31'h0, imem_req_valid}, {31'h0, !exp_fault});
  endtask

  task automatic fetch_one(input int rdy_wait, input int lat, input int stall, input logic [31:0] npc);
    goto_issue(rdy_wait, lat);
    retire(stall, npc);
  endtask

  initial begin
    int t0;
    logic [31:0] npc;
    rst             = 1'b1;
    npc_i           = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    model_reset();

    // Reset state
    tick();
    tick();
    check_reset_state("rst");
    check("rst_data", inst_data, 32'h0);

    // First fetch timing: idle cycle, then request at the reset PC
    rst = 1'b0;
    check("idle_reqv", {31'h0, imem_req_valid}, 32'h0);
    tick();
    check("first_addr", imem_addr, 32'h0000_3000);

    // Back-to-back sequential fetch, 3 cycles per instruction
    for (int i = 0; i < 3; i++) begin
      t0 = cyc;
      fetch_one(0, 0, 0, exp_pc + 32'd4);
      check("cpi3", cyc - t0, 32'd3);
    end
    check("cnt_after_3", retired_cnt, 32'd3);

    // Memory backpressure and core stall
    fetch_one(5, 0, 4, exp_pc + 32'd4);

    // Jump
    fetch_one(0, 1, 0, 32'h0040_0000);
    fetch_one(0, 0, 0, exp_pc + 32'd4);

    // Randomized traffic, aligned targets only
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) npc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      else npc = exp_pc + 32'd4;
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), npc);
    end

    // Reset coincident with retire: reset wins
    goto_issue(0, 0);
    inst_ready = 1'b1;
    npc_i      = exp_pc + 32'd4;
    rst        = 1'b1;
    tick();
    rst        = 1'b0;
    inst_ready = 1'b0;
    model_reset();
    check_reset_state("rst_retire");

    // Reset during WAIT, then stale responses in IDLE/REQ are ignored
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("wait_reached_reqv", {31'h0, imem_req_valid}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    check_reset_state("rst_wait");
    tick();
    check("stale_req_addr", imem_addr, 32'h0000_3000);
    tick();
    imem_resp_valid = 1'b0;
    check("stale_instv", {31'h0, inst_valid}, 32'h0);
    check("stale_data", inst_data, 32'h0);
    fetch_one(0, 2, 1, exp_pc + 32'd4);
    fetch_one(1, 0, 0, exp_pc + 32'd4);

    // Misaligned next PC -> sticky fault, no further requests
    fetch_one(0, 0, 0, 32'h0000_3102);
    for (int i = 0; i < 4; i++) begin
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      npc_i          = $urandom;
      tick();
      check("fault_reqv", {31'h0, imem_req_valid}, 32'h0);
      check("fault_instv", {31'h0, inst_valid}, 32'h0);
      check("fault_sticky", {31'h0, fetch_fault}, 32'h1);
      check("fault_pc_hold", fault_pc, 32'h0000_3102);
      check("fault_cnt_hold", retired_cnt, exp_cnt);
    end
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_reset_state("rst_fault");
    tick();
    fetch_one(0, 0, 0, exp_pc + 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
